// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl_pkg: shared state encodings, switch indices, BCD limits and ms-to-cycle helper
package clock_set_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, ED_ONES = 2'd1, ED_TENS = 2'd2} state_t;
  localparam int SW_MODE   = 0;
  localparam int SW_INC    = 1;
  localparam int SW_DEC    = 2;
  localparam int SW_CANCEL = 3;
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
  function automatic int ms2cyc(input int hz, input int ms);
    return hz / 1000 * ms;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_debounce.sv
// clock_set_ctrl_debounce: 2-FF synchroniser plus stability counter; emits level and one-cycle press
module clock_set_ctrl_debounce #(
  parameter int DB_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYC + 1);
  logic s1_q, s2_q, lvl_q, lvl_d, prs_q, prs_d, diff, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff  = s2_q != lvl_q;
    flip  = diff && cnt_q == CW'(DB_CYC - 1);
    cnt_d = (diff && !flip) ? cnt_q + CW'(1) : '0;
    lvl_d = flip ? s2_q : lvl_q;
    prs_d = lvl_d & ~lvl_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      prs_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      prs_q <= prs_d;
      cnt_q <= cnt_d;
    end
  end
  assign level = lvl_q;
  assign press = prs_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: debounced switch front end and BCD seconds time-setting FSM
// with auto-repeat, blink phase and one-cycle LOAD strobe toward the seconds counter.
module clock_set_ctrl import clock_set_ctrl_pkg::*; #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_MS     = 100,
  parameter int BLINK_MS      = 250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SW,
  input  logic [3:0] CUR_ONES,
  input  logic [3:0] CUR_TENS,
  output logic       EDIT,
  output logic       SEL_TENS,
  output logic [3:0] SET_ONES,
  output logic [3:0] SET_TENS,
  output logic       LOAD,
  output logic       BLINK
);
  localparam int DB_CYC  = ms2cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int DLY_CYC = ms2cyc(CLK_HZ, REPEAT_DLY_MS);
  localparam int RPT_CYC = ms2cyc(CLK_HZ, REPEAT_MS);
  localparam int BLK_CYC = ms2cyc(CLK_HZ, BLINK_MS);
  localparam int RW = $clog2(DLY_CYC + RPT_CYC + 1);
  localparam int BW = $clog2(BLK_CYC + 1);
  logic [3:0] level, press;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_db
    clock_set_ctrl_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk(CLK), .rst(RST), .raw(SW[i]), .level(level[i]), .press(press[i])
    );
  end
  state_t state_q, state_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d;
  logic load_q, load_d, blink_q, blink_d, rwait_q, rwait_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic hold, rep, inc_ev, dec_ev, up, dn, restart, bclr, btog;
  always_comb begin
    hold    = (state_q != RUN) & (level[SW_INC] ^ level[SW_DEC]);
    rep     = hold & (rcnt_q == (rwait_q ? RW'(DLY_CYC - 1) : RW'(RPT_CYC - 1)));
    inc_ev  = press[SW_INC] | (rep & level[SW_INC]);
    dec_ev  = press[SW_DEC] | (rep & level[SW_DEC]);
    up      = inc_ev & ~dec_ev;
    dn      = dec_ev & ~inc_ev;
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    load_d  = 1'b0;
    case (state_q)
      RUN: if (press[SW_MODE]) begin
        state_d = ED_ONES;
        ones_d  = (CUR_ONES > ONES_MAX) ? 4'd0 : CUR_ONES;
        tens_d  = (CUR_TENS > TENS_MAX) ? 4'd0 : CUR_TENS;
      end
      ED_ONES: begin
        state_d = press[SW_CANCEL] ? RUN : press[SW_MODE] ? ED_TENS : ED_ONES;
        if (!press[SW_CANCEL] && !press[SW_MODE])
          ones_d = up ? ((ones_q == ONES_MAX) ? 4'd0 : ones_q + 4'd1)
                 : dn ? ((ones_q == 4'd0) ? ONES_MAX : ones_q - 4'd1) : ones_q;
      end
      ED_TENS: begin
        state_d = (press[SW_CANCEL] | press[SW_MODE]) ? RUN : ED_TENS;
        load_d  = press[SW_MODE] & ~press[SW_CANCEL];
        if (!press[SW_CANCEL] && !press[SW_MODE])
          tens_d = up ? ((tens_q == TENS_MAX) ? 4'd0 : tens_q + 4'd1)
                 : dn ? ((tens_q == 4'd0) ? TENS_MAX : tens_q - 4'd1) : tens_q;
      end
      default: state_d = RUN;
    endcase
    // each fresh press or state change restarts the initial repeat delay
    restart = ~hold | press[SW_INC] | press[SW_DEC] | (state_d != state_q);
    rcnt_d  = (restart | rep) ? '0 : rcnt_q + RW'(1);
    rwait_d = restart ? 1'b1 : rep ? 1'b0 : rwait_q;
    bclr    = (state_d != state_q) | (state_d == RUN);
    btog    = bcnt_q == BW'(BLK_CYC - 1);
    bcnt_d  = (bclr | btog) ? '0 : bcnt_q + BW'(1);
    blink_d = bclr ? 1'b0 : btog ? ~blink_q : blink_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      ones_q  <= '0;
      tens_q  <= '0;
      load_q  <= 1'b0;
      blink_q <= 1'b0;
      rwait_q <= 1'b1;
      rcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      load_q  <= load_d;
      blink_q <= blink_d;
      rwait_q <= rwait_d;
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end
  assign EDIT     = state_q != RUN;
  assign SEL_TENS = state_q == ED_TENS;
  assign SET_ONES = ones_q;
  assign SET_TENS = tens_q;
  assign LOAD     = load_q;
  assign BLINK    = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scenario tasks for clock_set_ctrl at 10 cycles/ms
module tb_clock_set_ctrl;
  logic CLK = 1'b0, RST = 1'b1;
  logic [3:0] SW = '0, CUR_ONES = '0, CUR_TENS = '0;
  logic EDIT, SEL_TENS, LOAD, BLINK;
  logic [3:0] SET_ONES, SET_TENS;
  int tests = 0, fails = 0, loads = 0;

  clock_set_ctrl #(.CLK_HZ(10_000), .DEBOUNCE_MS(1), .REPEAT_DLY_MS(5), .REPEAT_MS(2), .BLINK_MS(2)) u_dut (
    .CLK(CLK), .RST(RST), .SW(SW), .CUR_ONES(CUR_ONES), .CUR_TENS(CUR_TENS),
    .EDIT(EDIT), .SEL_TENS(SEL_TENS), .SET_ONES(SET_ONES), .SET_TENS(SET_TENS),
    .LOAD(LOAD), .BLINK(BLINK)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (LOAD) loads++;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse(input logic [3:0] m, input int hold);
    SW = SW | m;
    tick(hold);
    SW = SW & ~m;
    tick(30);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick(3);
    tests++; if (EDIT !== 1'b0) begin fails++; $display("FAIL reset_edit got %b want 0", EDIT); end
    tests++; if (SEL_TENS !== 1'b0) begin fails++; $display("FAIL reset_sel got %b want 0", SEL_TENS); end
    tests++; if ({SET_TENS, SET_ONES} !== 8'h00) begin fails++; $display("FAIL reset_set got %h want 00", {SET_TENS, SET_ONES}); end
    tests++; if ({LOAD, BLINK} !== 2'b00) begin fails++; $display("FAIL reset_load_blink got %b want 00", {LOAD, BLINK}); end
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_bounce;
    int bp = 0, pc = 0, first = 0;
    for (int i = 0; i < 10; i++) begin
      SW[1] = (i % 2 == 0);
      repeat (3) begin @(negedge CLK); if (u_dut.press[1]) bp++; end
    end
    SW[1] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (u_dut.press[1]) begin pc++; if (first == 0) first = n; end
    end
    tests++; if (bp !== 0) begin fails++; $display("FAIL bounce_no_press got %0d want 0", bp); end
    tests++; if (pc !== 1) begin fails++; $display("FAIL bounce_one_press got %0d want 1", pc); end
    tests++; if (first < 12 || first > 13) begin fails++; $display("FAIL bounce_latency got %0d want 12..13", first); end
    SW[1] = 1'b0;
    tick(30);
    tests++; if ({EDIT, SET_ONES} !== 5'h00) begin fails++; $display("FAIL bounce_run_ignore got %h want 00", {EDIT, SET_ONES}); end
  endtask

  task automatic test_full_edit;
    int lc = 0;
    logic [7:0] at_load = '0;
    logic [1:0] eb = 2'b11;
    CUR_TENS = 4'd4; CUR_ONES = 4'd7;
    pulse(4'b0001, 20);
    tests++; if ({EDIT, SEL_TENS, SET_TENS, SET_ONES} !== 10'b10_0100_0111) begin fails++; $display("FAIL edit_capture got %b want 1001000111", {EDIT, SEL_TENS, SET_TENS, SET_ONES}); end
    repeat (3) pulse(4'b0010, 20);
    tests++; if (SET_ONES !== 4'd0) begin fails++; $display("FAIL edit_ones_wrap got %0d want 0", SET_ONES); end
    pulse(4'b0001, 20);
    tests++; if (SEL_TENS !== 1'b1) begin fails++; $display("FAIL edit_sel_tens got %b want 1", SEL_TENS); end
    pulse(4'b0100, 20);
    tests++; if ({SET_TENS, SET_ONES} !== 8'h30) begin fails++; $display("FAIL edit_tens_dec got %h want 30", {SET_TENS, SET_ONES}); end
    SW[0] = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge CLK);
      if (LOAD) begin lc++; at_load = {SET_TENS, SET_ONES}; eb = {EDIT, BLINK}; end
      if (n == 20) SW[0] = 1'b0;
    end
    tests++; if (lc !== 1) begin fails++; $display("FAIL edit_load_count got %0d want 1", lc); end
    tests++; if (at_load !== 8'h30) begin fails++; $display("FAIL edit_load_value got %h want 30", at_load); end
    tests++; if (eb !== 2'b00) begin fails++; $display("FAIL edit_load_edit_blink got %b want 00", eb); end
  endtask

  task automatic test_blink;
    int w = 0;
    CUR_TENS = 4'd2; CUR_ONES = 4'd1;
    SW[0] = 1'b1;
    while (EDIT !== 1'b1 && w < 40) begin @(negedge CLK); w++; end
    SW[0] = 1'b0;
    tests++; if (EDIT !== 1'b1) begin fails++; $display("FAIL blink_enter_timeout got %b want 1", EDIT); end
    tests++; if (BLINK !== 1'b0) begin fails++; $display("FAIL blink_entry got %b want 0", BLINK); end
    tick(19);
    tests++; if (BLINK !== 1'b0) begin fails++; $display("FAIL blink_before_toggle got %b want 0", BLINK); end
    tick(1);
    tests++; if (BLINK !== 1'b1) begin fails++; $display("FAIL blink_toggle1 got %b want 1", BLINK); end
    tick(20);
    tests++; if (BLINK !== 1'b0) begin fails++; $display("FAIL blink_toggle2 got %b want 0", BLINK); end
    tick(10);
    pulse(4'b1000, 20);
    tests++; if ({EDIT, BLINK} !== 2'b00) begin fails++; $display("FAIL blink_cancel got %b want 00", {EDIT, BLINK}); end
  endtask

  task automatic test_wrap_clamp;
    CUR_TENS = 4'd5; CUR_ONES = 4'd0;
    pulse(4'b0001, 20);
    pulse(4'b0100, 20);
    tests++; if (SET_ONES !== 4'd9) begin fails++; $display("FAIL wrap_ones_dec got %0d want 9", SET_ONES); end
    pulse(4'b0001, 20);
    pulse(4'b0010, 20);
    tests++; if (SET_TENS !== 4'd0) begin fails++; $display("FAIL wrap_tens_inc got %0d want 0", SET_TENS); end
    pulse(4'b0100, 20);
    tests++; if ({SET_TENS, SET_ONES} !== 8'h59) begin fails++; $display("FAIL wrap_tens_dec got %h want 59", {SET_TENS, SET_ONES}); end
    pulse(4'b1000, 20);
    tests++; if ({EDIT, SET_TENS, SET_ONES} !== 9'h059) begin fails++; $display("FAIL wrap_cancel_hold got %h want 059", {EDIT, SET_TENS, SET_ONES}); end
    CUR_TENS = 4'd7; CUR_ONES = 4'd12;
    pulse(4'b0001, 20);
    tests++; if ({EDIT, SET_TENS, SET_ONES} !== 9'h100) begin fails++; $display("FAIL clamp_capture got %h want 100", {EDIT, SET_TENS, SET_ONES}); end
    pulse(4'b1000, 20);
  endtask

  task automatic test_cancel_priority;
    int l0;
    CUR_TENS = 4'd3; CUR_ONES = 4'd2;
    pulse(4'b0001, 20);
    pulse(4'b0001, 20);
    tests++; if (SEL_TENS !== 1'b1) begin fails++; $display("FAIL prio_in_tens got %b want 1", SEL_TENS); end
    l0 = loads;
    pulse(4'b1001, 20);
    tests++; if (loads - l0 !== 0) begin fails++; $display("FAIL prio_cancel_no_load got %0d want 0", loads - l0); end
    tests++; if ({EDIT, SET_TENS, SET_ONES} !== 9'h032) begin fails++; $display("FAIL prio_cancel_state got %h want 032", {EDIT, SET_TENS, SET_ONES}); end
    pulse(4'b0001, 20);
    pulse(4'b0110, 20);
    tests++; if (SET_ONES !== 4'd2) begin fails++; $display("FAIL prio_inc_dec got %0d want 2", SET_ONES); end
    pulse(4'b1000, 20);
  endtask

  task automatic test_auto_repeat;
    CUR_TENS = 4'd0; CUR_ONES = 4'd0;
    pulse(4'b0001, 20);
    pulse(4'b0010, 120);
    tests++; if (SET_ONES !== 4'd5) begin fails++; $display("FAIL repeat_count got %0d want 5", SET_ONES); end
    pulse(4'b1000, 20);
  endtask

  task automatic test_async_reset;
    int l0;
    CUR_TENS = 4'd0; CUR_ONES = 4'd3;
    pulse(4'b0001, 20);
    pulse(4'b0010, 20);
    tests++; if ({EDIT, SET_ONES} !== 5'h14) begin fails++; $display("FAIL areset_pre got %h want 14", {EDIT, SET_ONES}); end
    l0 = loads;
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    tests++; if ({EDIT, SEL_TENS, LOAD, BLINK} !== 4'b0000) begin fails++; $display("FAIL areset_flags got %b want 0000", {EDIT, SEL_TENS, LOAD, BLINK}); end
    tests++; if ({SET_TENS, SET_ONES} !== 8'h00) begin fails++; $display("FAIL areset_set got %h want 00", {SET_TENS, SET_ONES}); end
    tick(2);
    RST = 1'b0;
    pulse(4'b0010, 20);
    tests++; if ({EDIT, SET_TENS, SET_ONES} !== 9'h000) begin fails++; $display("FAIL areset_run_inc got %h want 000", {EDIT, SET_TENS, SET_ONES}); end
    tests++; if (loads - l0 !== 0) begin fails++; $display("FAIL areset_no_load got %0d want 0", loads - l0); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_full_edit;
    test_blink;
    test_wrap_clamp;
    test_cancel_priority;
    test_auto_repeat;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
